// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer: FSM states,
// opcode values, IR field positions and the opcode class decode.
package control_pkg;

  localparam int OPW   = 5;
  localparam int NREGS = 16;
  localparam int DW    = 32;
  localparam int FW    = 4;

  localparam int OP_HI = 31;
  localparam int RA_HI = 26;
  localparam int RB_HI = 22;
  localparam int RC_HI = 18;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_BINARY, C_UNARY, C_WIDE, C_NOP, C_HALT, C_ILLEGAL
  } op_class_t;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  function automatic op_class_t classify(input logic [OPW-1:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        cls = C_BINARY;
      OP_NEG, OP_NOT:                         cls = C_UNARY;
      OP_MUL, OP_DIV:                         cls = C_WIDE;
      OP_NOP:                                 cls = C_NOP;
      OP_HALT:                                cls = C_HALT;
      default:                                cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/select_encode.sv
// Register select/encode: picks Ra, Rb or Rc from the IR and turns it into
// one-hot load (r_in) and bus-drive (r_out) enables.
module select_encode
  import control_pkg::*;
(
  input  logic [DW-1:0]    ir,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Rin,
  input  logic             Rout,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out
);

  logic [FW-1:0]    sel;
  logic [NREGS-1:0] onehot;
  logic             unused_ir;

  assign unused_ir = ^{ir[OP_HI:RA_HI+1], ir[RC_HI-FW:0]};

  always_comb begin
    sel = '0;
    if (Gra)      sel = ir[RA_HI -: FW];
    else if (Grb) sel = ir[RB_HI -: FW];
    else if (Grc) sel = ir[RC_HI -: FW];
    onehot      = '0;
    onehot[sel] = 1'b1;
    r_in  = Rin  ? onehot : '0;
    r_out = Rout ? onehot : '0;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps the datapath through fetch (T0-T2) and
// execute (T3-T6) one instruction at a time, with a Moore output decode.
module control_sequencer
  import control_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [DW-1:0]    ir,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [OPW-1:0]   alu_control,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic             halted
);

  state_t          state, state_next;
  op_class_t       op_class;
  logic [OPW-1:0]  op;
  logic            gra, grb, grc, rin, rout;

  assign op       = ir[OP_HI -: OPW];
  assign op_class = classify(op);
  assign busy     = (state != S_IDLE) && (state != S_HALT);

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    PCout       = 1'b0;
    MARin       = 1'b0;
    IncPC       = 1'b0;
    Zin         = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    alu_control = '0;
    gra         = 1'b0;
    grb         = 1'b0;
    grc         = 1'b0;
    rin         = 1'b0;
    rout        = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;

    case (state)
      S_IDLE: if (run) state_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_next = S_T1;
      end
      // Re-asserting PCin while waiting just rewrites the same Z value.
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_ready) state_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        case (op_class)
          C_BINARY, C_WIDE: begin
            grb = 1'b1; rout = 1'b1; Yin = 1'b1;
            state_next = S_T4;
          end
          C_UNARY: begin
            grb = 1'b1; rout = 1'b1; alu_control = op; Zin = 1'b1;
            state_next = S_T5;
          end
          C_NOP: begin
            instr_done = 1'b1;
            state_next = run ? S_T0 : S_IDLE;
          end
          C_HALT: begin
            instr_done = 1'b1;
            state_next = S_HALT;
          end
          default: begin
            instr_done = 1'b1; illegal = 1'b1;
            state_next = run ? S_T0 : S_IDLE;
          end
        endcase
      end
      S_T4: begin
        grc = 1'b1; rout = 1'b1; alu_control = op; Zin = 1'b1;
        state_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_class == C_WIDE) begin
          LOin = 1'b1;
          state_next = S_T6;
        end else begin
          gra = 1'b1; rin = 1'b1; instr_done = 1'b1;
          state_next = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
        state_next = run ? S_T0 : S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  select_encode u_select_encode (
    .ir    (ir),
    .Gra   (gra),
    .Grb   (grb),
    .Grc   (grc),
    .Rin   (rin),
    .Rout  (rout),
    .r_in  (r_in),
    .r_out (r_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks and/mul/neg/nop/halt/illegal
// instructions, memory wait, mid-op reset and run deassertion.
module tb_control_sequencer;

  logic        clk, clr, run, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [4:0]  alu_control;
  logic [15:0] r_in, r_out;
  logic busy, instr_done, illegal, halted;

  int checks = 0;
  int errors = 0;

  // Strobe vector bit order: PCout..LOin, MSB first.
  localparam logic [13:0] S_PCOUT = 14'h2000, S_MARIN = 14'h1000, S_INCPC = 14'h0800;
  localparam logic [13:0] S_ZIN   = 14'h0400, S_ZLO   = 14'h0200, S_ZHI   = 14'h0100;
  localparam logic [13:0] S_PCIN  = 14'h0080, S_READ  = 14'h0040, S_MDRIN = 14'h0020;
  localparam logic [13:0] S_MDROUT = 14'h0010, S_IRIN = 14'h0008, S_YIN   = 14'h0004;
  localparam logic [13:0] S_HIIN  = 14'h0002, S_LOIN  = 14'h0001;
  localparam logic [13:0] T0S = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
  localparam logic [13:0] T1S = S_ZLO | S_PCIN | S_READ | S_MDRIN;
  localparam logic [13:0] T2S = S_MDROUT | S_IRIN;
  localparam logic [3:0]  F_BUSY = 4'h8, F_DONE = 4'h4, F_ILL = 4'h2, F_HALT = 4'h1;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_MUL  = 32'h78918000;
  localparam logic [31:0] IR_NEG  = 32'h88918000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .alu_control(alu_control),
    .r_in(r_in), .r_out(r_out), .busy(busy), .instr_done(instr_done),
    .illegal(illegal), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic c, input logic r, input logic m, input logic [31:0] i);
    clr = c; run = r; mem_ready = m; ir = i;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] s, input logic [4:0] a,
                             input logic [15:0] ri, input logic [15:0] ro, input logic [3:0] f);
    logic [54:0] obs, exp_v;
    obs = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout,
           IRin, Yin, HIin, LOin, alu_control, r_in, r_out, busy, instr_done, illegal, halted};
    exp_v = {s, a, ri, ro, f};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 32'h0);
    step();
    checkOutput("reset_idle", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, IR_AND);
    step();
    checkOutput("idle_hold", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, IR_AND);
    checkOutput("idle_before_run", 0, 0, 0, 0, 0);
    step(); checkOutput("and_t0", T0S, 0, 0, 0, F_BUSY);
    step(); checkOutput("and_t1", T1S, 0, 0, 0, F_BUSY);
    step(); checkOutput("and_t2", T2S, 0, 0, 0, F_BUSY);
    step(); checkOutput("and_t3", S_YIN, 0, 0, 16'h0004, F_BUSY);
    step(); checkOutput("and_t4", S_ZIN, 5, 0, 16'h0008, F_BUSY);
    step(); checkOutput("and_t5", S_ZLO, 0, 16'h0002, 0, F_BUSY | F_DONE);
    step(); checkOutput("and_next_t0", T0S, 0, 0, 0, F_BUSY);

    applyStimulus(0, 1, 0, IR_AND);
    step(); checkOutput("wait_t1_1", T1S, 0, 0, 0, F_BUSY);
    step(); checkOutput("wait_t1_2", T1S, 0, 0, 0, F_BUSY);
    step(); checkOutput("wait_t1_3", T1S, 0, 0, 0, F_BUSY);
    applyStimulus(0, 1, 1, IR_MUL);
    checkOutput("wait_t1_4", T1S, 0, 0, 0, F_BUSY);
    step(); checkOutput("wait_t2", T2S, 0, 0, 0, F_BUSY);
    step(); checkOutput("mul_t3", S_YIN, 0, 0, 16'h0004, F_BUSY);
    step(); checkOutput("mul_t4", S_ZIN, 15, 0, 16'h0008, F_BUSY);
    step(); checkOutput("mul_t5", S_ZLO | S_LOIN, 0, 0, 0, F_BUSY);
    step(); checkOutput("mul_t6", S_ZHI | S_HIIN, 0, 0, 0, F_BUSY | F_DONE);
    step(); checkOutput("mul_next_t0", T0S, 0, 0, 0, F_BUSY);

    applyStimulus(0, 1, 1, IR_ILL);
    step(); step(); step();
    checkOutput("ill_t3", 0, 0, 0, 0, F_BUSY | F_DONE | F_ILL);
    step(); checkOutput("ill_next_t0", T0S, 0, 0, 0, F_BUSY);

    applyStimulus(0, 1, 1, IR_NOP);
    step(); step(); step();
    checkOutput("nop_t3", 0, 0, 0, 0, F_BUSY | F_DONE);
    step(); checkOutput("nop_next_t0", T0S, 0, 0, 0, F_BUSY);

    applyStimulus(0, 1, 1, IR_NEG);
    step(); step(); step();
    checkOutput("neg_t3", S_ZIN, 17, 0, 16'h0004, F_BUSY);
    step(); checkOutput("neg_t5", S_ZLO, 0, 16'h0002, 0, F_BUSY | F_DONE);
    step(); checkOutput("neg_next_t0", T0S, 0, 0, 0, F_BUSY);

    applyStimulus(0, 1, 1, IR_HALT);
    step(); step(); step();
    checkOutput("halt_t3", 0, 0, 0, 0, F_BUSY | F_DONE);
    step();
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt_hold", 0, 0, 0, 0, F_HALT);
      step();
    end
    applyStimulus(1, 1, 1, IR_HALT);
    checkOutput("halt_before_clr_edge", 0, 0, 0, 0, F_HALT);
    step(); checkOutput("halt_clr_idle", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, IR_AND);
    step(); checkOutput("halt_resume_t0", T0S, 0, 0, 0, F_BUSY);

    step(); step(); step(); step();
    checkOutput("rst_t4", S_ZIN, 5, 0, 16'h0008, F_BUSY);
    applyStimulus(1, 1, 1, IR_AND);
    step(); checkOutput("rst_idle", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, IR_AND);
    step(); checkOutput("rst_resume_t0", T0S, 0, 0, 0, F_BUSY);

    step(); step(); step();
    applyStimulus(0, 0, 1, IR_AND);
    checkOutput("drop_t3", S_YIN, 0, 0, 16'h0004, F_BUSY);
    step(); checkOutput("drop_t4", S_ZIN, 5, 0, 16'h0008, F_BUSY);
    step(); checkOutput("drop_t5", S_ZLO, 0, 16'h0002, 0, F_BUSY | F_DONE);
    step(); checkOutput("drop_idle", 0, 0, 0, 0, 0);
    step(); checkOutput("drop_idle_hold", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that sequences the datapath through fetch (T0-T2) and execute (T3-T6) for one instruction at a time.
- Drives every datapath strobe (PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin), alu_control and per-register in/out enables.
- Replaces the hand-timed strobe sequences of the datapath bench with a synthesizable FSM.
- Sits beside the datapath. Reads the IR contents back through `ir` and waits on memory via `mem_ready`.

Parameters:
- OPW, 5, opcode width (ir[31:27]).
- NREGS, 16, general registers. Field width is log2(NREGS)=4.
- DW, 32, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = keep fetching instructions.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- ir  in  DW  current IR register contents. Fields: op[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- alu_control  out  OPW  ALU operation.
- r_in  out  NREGS  one-hot register load enable.
- r_out  out  NREGS  one-hot register bus-drive enable.
- busy  out  1  high in T0..T6.
- instr_done  out  1  one-cycle pulse in the last execute cycle.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  high in HALT.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. A single state register; outputs are a Moore decode of state plus ir fields.
- Reset: on clk edge with clr=1, go to IDLE regardless of state, including mid-instruction. In IDLE every output is 0 and alu_control=0.
- IDLE -> T0 when run=1; otherwise stay in IDLE.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stay in T1 while mem_ready=0. Repeating PCin writes the same Z value, which is harmless.
  - -> T2 when mem_ready=1.
- T2: MDRout, IRin. Next state T3. `ir` is valid from T3 onward.
- Opcode classes:
  - Binary: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011.
  - Unary: neg 10001, not 10010.
  - Wide: mul 01111, div 10000.
  - Control: nop 11010, halt 11011.
  - Every other opcode is illegal.
- T3, by class:
  - Binary/wide: r_out[Rb], Yin. Next T4.
  - Unary: r_out[Rb], alu_control=op, Zin. Next T5.
  - nop: no strobes, instr_done. Next T0 if run, else IDLE.
  - illegal: no strobes, instr_done and illegal. Next T0 if run, else IDLE.
  - halt: no strobes, instr_done. Next HALT.
- T4 (binary/wide): r_out[Rc], alu_control=op, Zin. Next T5.
- T5:
  - Binary/unary: Zlowout, r_in[Ra], instr_done. Next T0 if run, else IDLE.
  - Wide: Zlowout, LOin. Next T6.
- T6 (wide only): Zhighout, HIin, instr_done. Next T0 if run, else IDLE.
- HALT: halted=1, all strobes 0. Only clr exits.
- alu_control is nonzero only in states where Zin is asserted.
- At most one of r_out bits, PCout, MDRout, Zlowout, Zhighout is high in any cycle (single bus driver).
- r_in and r_out are never both nonzero in the same cycle.
- Deasserting run mid-instruction finishes the current instruction; the check happens only at instruction end.
- clr has priority over mem_ready, run and halt.

Decomposition:
- Shared package control_pkg:
  - State encoding constants.
  - Opcode constants listed above.
  - Field-position constants (OP_HI=31, RA_HI=26, RB_HI=22, RC_HI=18).
- One sub-module, select_encode (combinational): inputs ir, Gra, Grb, Grc, Rin, Rout. Outputs r_in[NREGS-1:0] and r_out[NREGS-1:0] as 4-to-16 decodes of the selected field.
- The FSM drives Gra/Grb/Grc/Rin/Rout internally.

Test Plan:
- **and R1,R2,R3:** run=1, mem_ready=1, ir=0x28918000 from T3.
  - T3: r_out=0x0004, Yin.
  - T4: r_out=0x0008, alu_control=5, Zin.
  - T5: r_in=0x0002, Zlowout, instr_done.
  - Then T0.
- **Memory wait:** mem_ready low for 3 cycles after entering T1. Read/MDRin stay high for 4 cycles, and T2 follows on the cycle after mem_ready=1.
- **mul:** ir=0x78918000.
  - T4: alu_control=15.
  - T5: Zlowout+LOin, r_in=0.
  - T6: Zhighout+HIin, instr_done.
- **halt:** ir=0xD8000000. instr_done in T3, then halted=1 held for 20 cycles with all strobes 0 and run=1. clr returns to IDLE.
- **Illegal/nop:** ir=0xF8000000 gives an illegal+instr_done pulse in T3 and then T0. ir=0xD0000000 gives instr_done with no illegal.
- **Reset mid-op:** assert clr during T4 of and. The next cycle is IDLE with all outputs 0. Release clr with run=1 and the block resumes at T0.
